note_sequencer: RTL and testbench
=================================

# note_sequencer

Song-playback front end that drives the note interface of `chords`. It walks a song stored in a synchronous ROM and decodes each 16-bit entry into either a note event or a beat wait. Note events become one-cycle `note`/`duration`/`new_note` pulses for `chords`; the `beat` strobe paces playback. It sits between the song ROM and `chords`, and shares `play` and `beat` with it.

## Interface
- No parameters; field widths are fixed in `note_seq_pkg`.
- `clk` input 1 — system clock.
- `reset` input 1 — synchronous, active-high reset.
- `play` input 1 — run when high, pause (freeze) when low.
- `song` input 2 — selects the song; sampled continuously (see Operation).
- `beat` input 1 — one-cycle beat strobe, same as the one fed to `chords`.
- `rom_addr` output 7 — `{song_q, idx}`, where `idx` is 5 bits.
- `rom_data` input 16 — ROM word; valid one cycle after `rom_addr`.
- `note` output 6 — note index for `chords`.
- `duration` output 6 — note length in beats for `chords`.
- `new_note` output 1 — one-cycle note-issue strobe.
- `song_done` output 1 — one-cycle strobe at end of song.

## Operation
- ROM word format:
  - `[15]=0` is a note entry: `[14:9]` note, `[8:3]` duration, `[2:0]` ignored.
  - `[15]=1` is a wait entry: `[8:3]` beat count N; all other bits ignored.
  - `16'h0000` is the end marker.
- States: IDLE, FETCH, ROMWAIT, DECODE, WAITBEATS, DONE.
- IDLE:
  - On `play`=1: latch `song` into `song_q`, set `idx`=0, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH drives `rom_addr`, then goes to ROMWAIT.
- ROMWAIT goes to DECODE.
- DECODE samples `rom_data`:
  - Note entry: register `note`/`duration`, pulse `new_note` next cycle, `idx`++, go to FETCH.
  - Wait entry with N=0: `idx`++, go to FETCH.
  - Wait entry with N>0: load `beat_cnt`=N, `idx`++, go to WAITBEATS.
  - End marker: pulse `song_done`, go to DONE.
- WAITBEATS: each `beat` decrements `beat_cnt`; when it reaches 0, go to FETCH.
- DONE:
  - Stays in DONE until `play` goes low, then goes to IDLE.
  - Under the loop build, goes to FETCH with `idx`=0 instead of DONE (see Configuration).
- Index wrap: DECODE at `idx`=31 with a non-end entry processes the entry, then treats the next step as the end marker: pulses `song_done` and goes to DONE (or loops).
- Pause: while `play`=0 in any state other than IDLE/DONE, all state, `idx` and `beat_cnt` freeze.
  - `beat` is ignored while paused.
  - `new_note` is forced 0.
  - A `new_note` already scheduled for the next cycle is held and issued after `play` returns.
- Song change: when `song` ≠ `song_q` while not in IDLE, go to IDLE on the next cycle.
  - No `new_note` or `song_done` is issued on that cycle.
  - If `play`=1, IDLE restarts the new song from `idx` 0.
- Simultaneous events:
  - `reset` overrides everything.
  - Song change overrides pause.
  - `beat` arriving in the DECODE cycle that loads `beat_cnt` is not counted.

## Timing
- Reset values:
  - State IDLE; `idx`=0; `song_q`=0; `beat_cnt`=0.
  - Outputs: `rom_addr`=0, `note`=0, `duration`=0, `new_note`=0, `song_done`=0.
- Latency from `play` rising in IDLE to first `new_note` is 5 cycles: IDLE, FETCH, ROMWAIT, DECODE, then the strobe.
- Back-to-back note entries produce `new_note` every 3 cycles.
  - Each strobe is 1 cycle high with at least 2 low cycles between, which satisfies the `chords` requirement of at least 1 low cycle between strobes.
- `note`/`duration` are registered, change only with `new_note`, and hold their value otherwise.
- Wait entry of N beats: the next FETCH is the cycle after the N-th counted `beat`.

## Configuration
- `NOTE_SEQ_LOOP_EN` defined:
  - At end of song, pulse `song_done`, reset `idx` to 0 and go to FETCH.
  - Playback repeats indefinitely; DONE is unreachable.
- `NOTE_SEQ_LOOP_EN` undefined:
  - At end of song, go to DONE and stop until `play` is toggled low then high.
  - The toggle restarts from `idx` 0.

## Structure
- Package `note_seq_pkg` holds:
  - State enum.
  - Field positions: `NOTE_MSB/LSB`, `DUR_MSB/LSB`, `WAIT_BIT`.
  - Widths: `NOTE_W`=6, `IDX_W`=5.
  - `END_WORD`=16'h0000.
- One sub-module, `beat_counter`: loadable 6-bit down-counter that decrements on `beat & play` and flags `zero`.
- FSM, index and output registers live in the top.

## Test plan
1. Song 0 ROM holds `{0,37,4}`, `{0,41,4}`, `{0,44,4}`, END; `play`=1 → `new_note` at cycles 5, 8 and 11 with note 37/41/44 and duration 4, then `song_done` one cycle after the last DECODE, then DONE.
2. ROM holds `{0,37,4}`, WAIT N=2, `{0,41,4}`; `beat` every 25 cycles → second `new_note` appears 4 cycles after the 2nd `beat` following the wait decode.
3. Drop `play` for 10 cycles between the two notes of scenario 1 → second strobe is delayed exactly 10 cycles; beats during the pause are not counted.
4. `song` changes 0→1 mid-WAITBEATS → `rom_addr` restarts at 7'h20; no stray `new_note`.
5. Song with 32 non-end entries → `song_done` after `idx` 31; no wrap to `idx` 0 unless the loop build is used.
6. Loop build with `NOTE_SEQ_LOOP_EN` → after END, `new_note` for note 37 recurs 5 cycles after `song_done`; `reset` mid-song returns all outputs to 0 next cycle.

Source files
------------

// File: rtl/note_seq_pkg.sv
// Shared types and ROM word layout for the note sequencer.
// Field positions, widths, end marker and FSM state encoding.
package note_seq_pkg;

    localparam int NOTE_W   = 6;
    localparam int DUR_W    = 6;
    localparam int IDX_W    = 5;
    localparam int SONG_W   = 2;
    localparam int ADDR_W   = SONG_W + IDX_W;

    localparam int NOTE_MSB = 14;
    localparam int NOTE_LSB = 9;
    localparam int DUR_MSB  = 8;
    localparam int DUR_LSB  = 3;
    localparam int WAIT_BIT = 15;

    localparam logic [15:0] END_WORD = 16'h0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ROMWAIT,
        S_DECODE,
        S_WAITBEATS,
        S_DONE
    } state_e;

endpackage

// File: rtl/note_sequencer_beat_counter.sv
// Loadable down-counter of beats for wait entries.
// Load wins over decrement; expire_o flags the decrement that hits zero.
module beat_counter
    import note_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [DUR_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o,
    output logic             expire_o
);

    logic [DUR_W-1:0] cnt_q;
    logic [DUR_W-1:0] cnt_d;

    // Next count: load has priority, decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - DUR_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o   = (cnt_q == '0);
    assign expire_o = dec_i && (cnt_q == DUR_W'(1));

endmodule

// File: rtl/note_sequencer.sv
// Song ROM walker issuing note/duration/new_note pulses for chords.
// Define NOTE_SEQ_LOOP_EN to repeat the song instead of stopping in DONE.
module note_sequencer
    import note_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic [SONG_W-1:0] song,
    input  logic              beat,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [NOTE_W-1:0] note,
    output logic [DUR_W-1:0]  duration,
    output logic              new_note,
    output logic              song_done
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SONG_W-1:0] song_q, song_d;
    logic              last_q, last_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic              nn_q, nn_d;
    logic              done_q, done_d;

    logic              song_chg;
    logic              end_hit;
    logic              is_end;
    logic              is_wait;
    logic [DUR_W-1:0]  wait_n;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;
    logic              cnt_expire;
    logic              unused_bits;

    assign song_chg    = (state_q != S_IDLE) && (song != song_q);
    assign is_end      = (rom_data == END_WORD);
    assign is_wait     = rom_data[WAIT_BIT];
    assign wait_n      = rom_data[DUR_MSB:DUR_LSB];
    assign cnt_dec     = beat && play && !song_chg
                         && (state_q == S_WAITBEATS);
    assign unused_bits = ^rom_data[2:0];

    beat_counter u_beat_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (wait_n),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero),
        .expire_o   (cnt_expire)
    );

    // Next-state, index and pulse scheduling.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        song_d   = song_q;
        last_d   = last_q;
        note_d   = note_q;
        dur_d    = dur_q;
        nn_d     = nn_q;
        done_d   = 1'b0;
        end_hit  = 1'b0;
        cnt_load = 1'b0;

        // A pending strobe is consumed by the first running cycle.
        if (play) begin
            nn_d = 1'b0;
        end

        if (song_chg) begin
            state_d = S_IDLE;
            nn_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (play) begin
                        song_d  = song;
                        idx_d   = '0;
                        last_d  = 1'b0;
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (play) begin
                        if (last_q) begin
                            end_hit = 1'b1;
                        end else begin
                            state_d = S_ROMWAIT;
                        end
                    end
                end
                S_ROMWAIT: begin
                    if (play) begin
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (play) begin
                        if (is_end) begin
                            end_hit = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                            if (idx_q == '1) begin
                                last_d = 1'b1;
                            end
                            if (!is_wait) begin
                                note_d  = rom_data[NOTE_MSB:NOTE_LSB];
                                dur_d   = rom_data[DUR_MSB:DUR_LSB];
                                nn_d    = 1'b1;
                                state_d = S_FETCH;
                            end else if (wait_n == '0) begin
                                state_d = S_FETCH;
                            end else begin
                                cnt_load = 1'b1;
                                state_d  = S_WAITBEATS;
                            end
                        end
                    end
                end
                S_WAITBEATS: begin
                    if (play && (cnt_expire || cnt_zero)) begin
                        state_d = S_FETCH;
                    end
                end
                S_DONE: begin
                    if (!play) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (end_hit) begin
                done_d = 1'b1;
`ifdef NOTE_SEQ_LOOP_EN
                idx_d   = '0;
                last_d  = 1'b0;
                state_d = S_FETCH;
`else
                state_d = S_DONE;
`endif
            end
        end
    end

    // State, index and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            song_q  <= '0;
            last_q  <= 1'b0;
            note_q  <= '0;
            dur_q   <= '0;
            nn_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            song_q  <= song_d;
            last_q  <= last_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
            nn_q    <= nn_d;
            done_q  <= done_d;
        end
    end

    assign rom_addr  = {song_q, idx_q};
    assign note      = note_q;
    assign duration  = dur_q;
    assign new_note  = nn_q && play && !song_chg;
    assign song_done = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer (default build, no looping).
// Expected strobes with their cycle stamps are queued as stimulus is driven.
module tb_note_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        play;
    logic [1:0]  song;
    logic        beat;
    logic [6:0]  rom_addr;
    logic [15:0] rom_data;
    logic [5:0]  note;
    logic [5:0]  duration;
    logic        new_note;
    logic        song_done;

    logic [15:0] mem [128];

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int c0;

    typedef struct {
        int kind;
        int nt;
        int du;
        int at;
    } ev_t;

    ev_t sb[$];

    note_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .song      (song),
        .beat      (beat),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .note      (note),
        .duration  (duration),
        .new_note  (new_note),
        .song_done (song_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) rom_data <= mem[rom_addr];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] nw(int n, int d);
        return {1'b0, 6'(n), 6'(d), 3'b000};
    endfunction

    function automatic logic [15:0] ww(int n);
        return {1'b1, 6'd0, 6'(n), 3'b000};
    endfunction

    task automatic push(int kind, int nt, int du, int at);
        ev_t e;
        e.kind = kind;
        e.nt   = nt;
        e.du   = du;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        play  = 1'b0;
        beat  = 1'b0;
        song  = 2'd0;
        step();
        step();
        reset = 1'b0;
        sb.delete();
    endtask

    // Compare every strobe the DUT produces against the queue head.
    always @(negedge clk) begin
        ev_t e;
        if (!reset && (new_note || song_done)) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {30'd0, new_note, song_done}, 0);
            end else begin
                e = sb.pop_front();
                chk("kind", new_note ? 1 : 2, e.kind);
                if (new_note) begin
                    chk("note", note, e.nt);
                    chk("dur", duration, e.du);
                end
                if (e.at >= 0) chk("cycle", cyc, e.at);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Scenario 1: three notes then END, then replay after toggle.
        clear_mem();
        mem[0] = nw(37, 4);
        mem[1] = nw(41, 4);
        mem[2] = nw(44, 4);
        do_reset();
        chk("rst_addr", rom_addr, 0);
        chk("rst_note", note, 0);
        chk("rst_dur", duration, 0);
        chk("rst_new_note", new_note, 0);
        chk("rst_done", song_done, 0);
        play = 1'b1;
        c0 = cyc;
        push(1, 37, 4, c0 + 4);
        push(1, 41, 4, c0 + 7);
        push(1, 44, 4, c0 + 10);
        push(2, 0, 0, c0 + 13);
        repeat (20) step();
        chk("s1_left", sb.size(), 0);
        chk("s1_note_hold", note, 44);
        chk("s1_dur_hold", duration, 4);
        play = 1'b0;
        step();
        step();
        play = 1'b1;
        c0 = cyc;
        push(1, 37, 4, c0 + 4);
        push(1, 41, 4, c0 + 7);
        push(1, 44, 4, c0 + 10);
        push(2, 0, 0, c0 + 13);
        repeat (20) step();
        chk("s1_replay_left", sb.size(), 0);

        // Scenario 2: wait of 2 beats, beats in DECODE and pause ignored.
        clear_mem();
        mem[0] = nw(37, 4);
        mem[1] = ww(2);
        mem[2] = nw(41, 4);
        do_reset();
        c0 = cyc;
        push(1, 37, 4, c0 + 4);
        push(1, 41, 4, c0 + 54);
        push(2, 0, 0, c0 + 57);
        for (int k = 0; k < 70; k++) begin
            play = !(k >= 30 && k < 40);
            beat = (k == 6) || (k == 25) || (k == 32)
                   || (k == 35) || (k == 50);
            step();
        end
        beat = 1'b0;
        chk("s2_left", sb.size(), 0);

        // Scenario 3: 10-cycle pause, then pause over a pending strobe.
        clear_mem();
        mem[0] = nw(37, 4);
        mem[1] = nw(41, 4);
        mem[2] = nw(44, 4);
        do_reset();
        c0 = cyc;
        push(1, 37, 4, c0 + 4);
        push(1, 41, 4, c0 + 20);
        push(1, 44, 4, c0 + 23);
        push(2, 0, 0, c0 + 26);
        for (int k = 0; k < 40; k++) begin
            play = !((k >= 5 && k < 15) || (k >= 17 && k < 20));
            step();
        end
        chk("s3_left", sb.size(), 0);

        // Scenario 4: song change mid-wait restarts at song 1.
        clear_mem();
        mem[0]  = nw(37, 4);
        mem[1]  = ww(3);
        mem[2]  = nw(41, 4);
        mem[32] = nw(50, 2);
        mem[33] = nw(51, 2);
        do_reset();
        c0 = cyc;
        push(1, 37, 4, c0 + 4);
        push(1, 50, 2, c0 + 15);
        push(1, 51, 2, c0 + 18);
        push(2, 0, 0, c0 + 21);
        for (int k = 0; k < 30; k++) begin
            play = 1'b1;
            song = (k >= 10) ? 2'd1 : 2'd0;
            beat = (k == 8);
            if (k == 10) chk("s4_addr_pre", rom_addr, 7'h02);
            if (k == 12) chk("s4_addr_restart", rom_addr, 7'h20);
            step();
        end
        chk("s4_left", sb.size(), 0);

        // Scenario 5: 32 notes with no END, must stop after idx 31.
        clear_mem();
        for (int i = 0; i < 32; i++) mem[64 + i] = nw(i + 1, 1);
        do_reset();
        c0 = cyc;
        for (int i = 0; i < 32; i++) push(1, i + 1, 1, c0 + 4 + 3 * i);
        push(2, 0, 0, -1);
        for (int k = 0; k < 130; k++) begin
            play = 1'b1;
            song = 2'd2;
            step();
        end
        chk("s5_left", sb.size(), 0);

        // Scenario 6: reset mid-song clears all outputs next cycle.
        clear_mem();
        mem[0] = nw(37, 4);
        mem[1] = nw(41, 4);
        mem[2] = nw(44, 4);
        do_reset();
        c0 = cyc;
        push(1, 37, 4, c0 + 4);
        play = 1'b1;
        repeat (5) step();
        reset = 1'b1;
        play  = 1'b0;
        step();
        reset = 1'b0;
        chk("s6_addr", rom_addr, 0);
        chk("s6_note", note, 0);
        chk("s6_dur", duration, 0);
        chk("s6_new_note", new_note, 0);
        chk("s6_done", song_done, 0);
        repeat (10) step();
        chk("s6_left", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
